// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-wide memory without byte enables.
// Sub-word stores use read-modify-write. Define MISALIGN_SPLIT_EN to serve misaligned and word-spanning accesses.
module load_store_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         resp_error,
    output logic [N-1:0] mem_addr,
    output logic         mem_enable_data,
    output logic [N-1:0] mem_write_data,
    input  logic [N-1:0] mem_read_data
);

`ifdef MISALIGN_SPLIT_EN
    localparam logic SPLIT = 1'b1;
`else
    localparam logic SPLIT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;
    state_t state, state_nxt;

    logic         we_q, err_q;
    logic [2:0]   f3_q;
    logic [N-1:0] addr_q, wdata_q, buf0, buf1;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] o, input logic [2:0] sz);
        return ((sz == 3'd2) && o[0]) || ((sz == 3'd4) && (o != 2'b00));
    endfunction

    function automatic logic [N-1:0] size_mask(input logic [2:0] sz);
        case (sz)
            3'd1:    return {{(N-8){1'b0}}, 8'hFF};
            3'd2:    return {{(N-16){1'b0}}, 16'hFFFF};
            default: return {N{1'b1}};
        endcase
    endfunction

    logic [2:0]   in_sz, sz;
    logic         in_mis, in_err, spans;
    logic [N-1:0] w0, w1, szmask, raw, load_ext;
    logic [4:0]   sh;
    logic [2*N-1:0] line, lane_mask, merged, shifted;

    assign in_sz  = size_of(req_funct3);
    assign in_mis = is_misaligned(req_addr[1:0], in_sz);
    assign in_err = is_illegal(req_we, req_funct3) || (in_mis && !SPLIT);

    assign sz     = size_of(f3_q);
    assign spans  = SPLIT && (({1'b0, addr_q[1:0]} + sz) > 3'd4);
    assign w0     = {addr_q[N-1:2], 2'b00};
    assign w1     = w0 + N'(4);
    assign sh     = {addr_q[1:0], 3'b000};
    assign szmask = size_mask(sz);

    // Two fetched words form a byte line; stores merge into it, loads shift out of it.
    assign line      = {buf1, buf0};
    assign lane_mask = {{N{1'b0}}, szmask} << sh;
    assign merged    = (line & ~lane_mask) | ({{N{1'b0}}, wdata_q & szmask} << sh);
    assign shifted   = line >> sh;
    assign raw       = shifted[N-1:0] & szmask;

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{(N-8){raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{(N-16){raw[15]}}, raw[15:0]};
            default: load_ext = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                err_q   <= in_err;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == RD0) buf0 <= mem_read_data;
            if (state == RD1) buf1 <= mem_read_data;
        end
    end

    // Outputs are held at reset values whenever rst is high, so no write or response leaks out.
    always_comb begin
        state_nxt       = state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_error      = 1'b0;
        mem_addr        = '0;
        mem_enable_data = 1'b0;
        mem_write_data  = '0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    if (in_err)
                        state_nxt = RESP;
                    else if (req_we && req_funct3 == 3'b010 && !in_mis)
                        state_nxt = WR0;
                    else
                        state_nxt = RD0;
                end
            end
            RD0: begin
                mem_addr = rst ? '0 : w0;
                if (spans)      state_nxt = RD1;
                else if (!we_q) state_nxt = RESP;
                else            state_nxt = WR0;
            end
            RD1: begin
                mem_addr  = rst ? '0 : w1;
                state_nxt = we_q ? WR0 : RESP;
            end
            WR0: begin
                if (!rst) begin
                    mem_addr        = w0;
                    mem_enable_data = 1'b1;
                    mem_write_data  = merged[N-1:0];
                end
                state_nxt = spans ? WR1 : RESP;
            end
            WR1: begin
                if (!rst) begin
                    mem_addr        = w1;
                    mem_enable_data = 1'b1;
                    mem_write_data  = merged[2*N-1:N];
                end
                state_nxt = RESP;
            end
            RESP: begin
                if (!rst) begin
                    resp_valid = 1'b1;
                    resp_error = err_q;
                    resp_rdata = (err_q || we_q) ? '0 : load_ext;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word memory model plus a response scoreboard.
// Expectations follow MISALIGN_SPLIT_EN when it is defined for the build.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_error, mem_enable_data;
    logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;

    load_store_unit #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_addr(mem_addr), .mem_enable_data(mem_enable_data),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign mem_read_data = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_enable_data) mem[mem_addr[7:2]] <= mem_write_data;
        else if (pl_en)      mem[pl_idx] <= pl_data;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int last_nwr, last_first_wr;
    logic [31:0] last_wr_addr;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = addr[7:2]; pl_data = data;
        @(posedge clk); #1 pl_en = 1'b0;
    endtask

    task automatic check_mem(input string name, input logic [31:0] addr, input logic [31:0] exp);
        total++;
        if (mem[addr[7:2]] !== exp) begin
            bad++;
            $display("FAIL %s: mem[%h] got %h want %h", name, addr, mem[addr[7:2]], exp);
        end
    endtask

    task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int   lat;
        logic got;
        exp_t e;
        sb.push_back('{rdata: exp_rd, err: exp_err, lat: exp_lat});
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready: got %b want 1", name, req_ready);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0; got = 1'b0; last_nwr = 0; last_first_wr = -1; last_wr_addr = '0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (mem_enable_data) begin
                last_nwr++;
                if (last_first_wr < 0) begin
                    last_first_wr = lat;
                    last_wr_addr  = mem_addr;
                end
            end
            if (resp_valid) got = 1'b1;
        end
        e = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s timeout: no resp_valid within %0d cycles", name, lat);
        end else begin
            if (resp_rdata !== e.rdata || resp_error !== e.err || lat != e.lat) begin
                bad++;
                $display("FAIL %s resp: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         name, resp_rdata, resp_error, lat, e.rdata, e.err, e.lat);
            end
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s after_resp: got valid=%b ready=%b want 0/1", name, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0 ||
            mem_addr !== 32'h0 || mem_enable_data !== 1'b0 || mem_write_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b addr=%h we=%b wd=%h want all 0",
                     req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_enable_data, mem_write_data);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word;
        run_req("sw_aligned", 1'b1, F_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        total++;
        if (last_first_wr != 1 || last_nwr != 1 || last_wr_addr !== 32'h10) begin
            bad++;
            $display("FAIL sw_write: got cycle=%0d writes=%0d addr=%h want 1/1/00000010",
                     last_first_wr, last_nwr, last_wr_addr);
        end
        check_mem("sw_mem", 32'h10, 32'hDEADBEEF);
        run_req("lw_aligned", 1'b0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    endtask

    task automatic test_subword_load;
        poke(32'h20, 32'h80FF7F01);
        run_req("lb_sign", 1'b0, F_B, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        run_req("lbu",     1'b0, F_BU, 32'h23, 32'h0, 32'h00000080, 1'b0, 2);
        run_req("lh_sign", 1'b0, F_H, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2);
        run_req("lhu",     1'b0, F_HU, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2);
        run_req("lb_pos",  1'b0, F_B, 32'h21, 32'h0, 32'h0000007F, 1'b0, 2);
    endtask

    task automatic test_subword_store;
        poke(32'h20, 32'h11223344);
        run_req("sb_rmw", 1'b1, F_B, 32'h21, 32'h000000AB, 32'h0, 1'b0, 3);
        total++;
        if (last_first_wr != 2 || last_nwr != 1) begin
            bad++;
            $display("FAIL sb_write_cycle: got cycle=%0d writes=%0d want 2/1", last_first_wr, last_nwr);
        end
        check_mem("sb_mem", 32'h20, 32'h1122AB44);
        run_req("sh_rmw", 1'b1, F_H, 32'h22, 32'hFFFFBEEF, 32'h0, 1'b0, 3);
        check_mem("sh_mem", 32'h20, 32'hBEEFAB44);
    endtask

    task automatic test_misaligned;
        poke(32'h30, 32'h44332211);
        poke(32'h34, 32'h88776655);
`ifdef MISALIGN_SPLIT_EN
        run_req("lw_span", 1'b0, F_W, 32'h33, 32'h0, 32'h77665544, 1'b0, 3);
        run_req("lh_mis",  1'b0, F_H, 32'h21, 32'h0, 32'hFFFFEFAB, 1'b0, 2);
        run_req("sw_span", 1'b1, F_W, 32'h33, 32'hAABBCCDD, 32'h0, 1'b0, 5);
        total++;
        if (last_nwr != 2) begin
            bad++;
            $display("FAIL sw_span_writes: got %0d want 2", last_nwr);
        end
        check_mem("sw_span_w0", 32'h30, 32'hDD332211);
        check_mem("sw_span_w1", 32'h34, 32'h88AABBCC);
`else
        run_req("lw_mis_err", 1'b0, F_W, 32'h33, 32'h0, 32'h0, 1'b1, 1);
        run_req("sw_mis_err", 1'b1, F_W, 32'h33, 32'hAABBCCDD, 32'h0, 1'b1, 1);
        total++;
        if (last_nwr != 0) begin
            bad++;
            $display("FAIL sw_mis_nowrite: got writes=%0d want 0", last_nwr);
        end
        run_req("lh_mis_err", 1'b0, F_H, 32'h21, 32'h0, 32'h0, 1'b1, 1);
        check_mem("mis_w0_untouched", 32'h30, 32'h44332211);
        check_mem("mis_w1_untouched", 32'h34, 32'h88776655);
`endif
    endtask

    task automatic test_illegal;
        run_req("ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1);
        run_req("ld_f3_110", 1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 1'b1, 1);
        run_req("st_f3_100", 1'b1, F_BU, 32'h20, 32'h12345678, 32'h0, 1'b1, 1);
        total++;
        if (last_nwr != 0) begin
            bad++;
            $display("FAIL illegal_store_nowrite: got writes=%0d want 0", last_nwr);
        end
        check_mem("illegal_mem", 32'h20, 32'hBEEFAB44);
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            run_req("b2b_sw", 1'b1, F_W, 32'h40 + 32'(4 * i), v, 32'h0, 1'b0, 2);
            run_req("b2b_lw", 1'b0, F_W, 32'h40 + 32'(4 * i), 32'h0, v, 1'b0, 2);
        end
        run_req("b2b_lw_top", 1'b0, F_W, 32'hFC, 32'h0, 32'h0BADF00D, 1'b0, 2);
    endtask

    task automatic reset_mid(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int rst_cycle);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1 req_valid = 1'b0;
        for (int k = 1; k < rst_cycle; k++) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (mem_enable_data !== 1'b0 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s during_rst: got we=%b valid=%b want 0/0", name, mem_enable_data, resp_valid);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s after_rst: got ready=%b valid=%b want 1/0", name, req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_mid_op;
        poke(32'h28, 32'h55667788);
        reset_mid("rst_wr0", F_B, 32'h29, 32'h000000CC, 2);
        check_mem("rst_wr0_mem", 32'h28, 32'h55667788);
`ifdef MISALIGN_SPLIT_EN
        poke(32'h30, 32'h44332211);
        poke(32'h34, 32'h88776655);
        reset_mid("rst_wr1", F_W, 32'h33, 32'h12345678, 4);
        check_mem("rst_wr1_w0", 32'h30, 32'h78332211);
        check_mem("rst_wr1_w1", 32'h34, 32'h88776655);
`endif
        run_req("post_rst_lw", 1'b0, F_W, 32'h28, 32'h0, 32'h55667788, 1'b0, 2);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[63] = 32'h0BADF00D;
        test_reset();
        test_word();
        test_subword_load();
        test_subword_store();
        test_misaligned();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
